// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
// Holds the bus width, the idle-drive constants, the FSM/grantee encodings and the latched request.
package mem_port_arbiter_pkg;

  localparam int               REG_W         = 32;
  localparam logic [REG_W-1:0] ZERO_WORD     = '0;
  localparam logic             CHIP_ENABLE   = 1'b1;
  localparam logic             CHIP_DISABLE  = 1'b0;
  localparam logic             WRITE_ENABLE  = 1'b1;
  localparam logic             WRITE_DISABLE = 1'b0;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_e;
  typedef enum logic {GNT_IF   = 1'b0, GNT_LS   = 1'b1} arb_gnt_e;

  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] addr;
    logic [REG_W-1:0] data;
    logic [3:0]       sel;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter bundled as one interface.
// slave = arbiter side, master = core pipeline / wishbone buffer side.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic             if_req_i;
  logic [REG_W-1:0] if_addr_i;
  logic             if_ack_o;
  logic [REG_W-1:0] if_data_o;
  logic             ls_req_i;
  logic             ls_we_i;
  logic [REG_W-1:0] ls_addr_i;
  logic [REG_W-1:0] ls_data_i;
  logic [3:0]       ls_sel_i;
  logic             ls_ack_o;
  logic [REG_W-1:0] ls_data_o;
  logic             stall_req_o;
  logic             mem_ce_o;
  logic             mem_we_o;
  logic [REG_W-1:0] mem_addr_o;
  logic [REG_W-1:0] mem_data_o;
  logic [3:0]       mem_sel_o;
  logic [REG_W-1:0] mem_data_i;

  modport slave (
    input  if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_data_i, ls_sel_i, mem_data_i,
    output if_ack_o, if_data_o, ls_ack_o, ls_data_o, stall_req_o,
           mem_ce_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o
  );

  modport master (
    output if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_data_i, ls_sel_i, mem_data_i,
    input  if_ack_o, if_data_o, ls_ack_o, ls_data_o, stall_req_o,
           mem_ce_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational priority picker: LS over IF unless the LS streak has hit its limit,
// with an optional requester masked out (the one completing this cycle).
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_LS_STREAK = 4
) (
  input  logic       i_if_req,
  input  logic       i_ls_req,
  input  logic [3:0] i_streak,
  input  logic       i_excl_vld,
  input  arb_gnt_e   i_excl,
  output logic       o_vld,
  output arb_gnt_e   o_gnt
);

  logic w_if, w_ls;

  always_comb begin
    w_if  = i_if_req & ~(i_excl_vld & (i_excl == GNT_IF));
    w_ls  = i_ls_req & ~(i_excl_vld & (i_excl == GNT_LS));
    o_vld = w_if | w_ls;
    if (w_if && (!w_ls || i_streak == 4'(MAX_LS_STREAK))) o_gnt = GNT_IF;
    else                                                  o_gnt = GNT_LS;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single CPU memory port between instruction fetch and load/store,
// holding each access WAIT_CYCLES+1 cycles and stalling the pipeline while requests are open.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES   = 0,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  arb_state_e r_state, w_state_nxt;
  arb_gnt_e   r_gnt, w_pick;
  logic [3:0] r_cnt, r_streak;
  mem_req_t   r_req, w_req_nxt;
  logic       w_busy, w_done, w_pick_vld, w_load;

  assign w_busy = (r_state == ARB_BUSY);
  assign w_done = w_busy && (r_cnt == 4'd0);

  // On the completion edge the served requester still holds req; mask it so it is not regranted.
  mem_arb_pick #(.MAX_LS_STREAK(MAX_LS_STREAK)) u_pick (
    .i_if_req   (bus.if_req_i),
    .i_ls_req   (bus.ls_req_i),
    .i_streak   (r_streak),
    .i_excl_vld (w_done),
    .i_excl     (r_gnt),
    .o_vld      (w_pick_vld),
    .o_gnt      (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ARB_IDLE: if (w_pick_vld) begin
        w_state_nxt = ARB_BUSY;
        w_load      = 1'b1;
      end
      ARB_BUSY: if (w_done) begin
        if (w_pick_vld) w_load      = 1'b1;
        else            w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_req_nxt.we   = WRITE_DISABLE;
    w_req_nxt.addr = bus.if_addr_i;
    w_req_nxt.data = ZERO_WORD;
    w_req_nxt.sel  = 4'b1111;
    if (w_pick == GNT_LS) begin
      w_req_nxt.we   = bus.ls_we_i;
      w_req_nxt.addr = bus.ls_addr_i;
      w_req_nxt.data = bus.ls_data_i;
      w_req_nxt.sel  = bus.ls_sel_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ARB_IDLE;
      r_gnt    <= GNT_IF;
      r_cnt    <= '0;
      r_streak <= '0;
      r_req    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_gnt <= w_pick;
        r_cnt <= 4'(WAIT_CYCLES);
        r_req <= w_req_nxt;
        if (w_pick == GNT_IF)
          r_streak <= '0;
        else if (bus.if_req_i && r_streak != 4'(MAX_LS_STREAK))
          r_streak <= r_streak + 4'd1;
      end else if (w_busy && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign bus.mem_ce_o    = w_busy ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.mem_we_o    = (w_busy && r_req.we) ? WRITE_ENABLE : WRITE_DISABLE;
  assign bus.mem_addr_o  = w_busy ? r_req.addr : ZERO_WORD;
  assign bus.mem_data_o  = w_busy ? r_req.data : ZERO_WORD;
  assign bus.mem_sel_o   = w_busy ? r_req.sel  : 4'b0000;

  assign bus.if_ack_o    = w_done && (r_gnt == GNT_IF);
  assign bus.ls_ack_o    = w_done && (r_gnt == GNT_LS);
  assign bus.if_data_o   = bus.if_ack_o ? bus.mem_data_i : ZERO_WORD;
  assign bus.ls_data_o   = (bus.ls_ack_o && !r_req.we) ? bus.mem_data_i : ZERO_WORD;
  assign bus.stall_req_o = (bus.if_req_i & ~bus.if_ack_o) | (bus.ls_req_i & ~bus.ls_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (WAIT_CYCLES=2/MAX_LS_STREAK=2 and WAIT_CYCLES=0),
// expected acks queued in service order and matched when each ack appears.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct packed {
    logic        is_ls;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk, rst;
  int   n_cmp, n_bad;
  exp_t q_a[$], q_b[$];
  exp_t e_a, e_b;

  mem_port_arbiter_if bus_a();
  mem_port_arbiter_if bus_b();

  mem_port_arbiter #(.WAIT_CYCLES(2), .MAX_LS_STREAK(2)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_port_arbiter #(.WAIT_CYCLES(0), .MAX_LS_STREAK(4)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  function automatic logic [31:0] rd_a(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory models: A returns an address-derived word, B a fixed pattern.
  assign bus_a.mem_data_i = rd_a(bus_a.mem_addr_o);
  assign bus_b.mem_data_i = 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst && (bus_a.if_ack_o || bus_a.ls_ack_o)) begin
      chk("a_ack_excl", {31'd0, bus_a.if_ack_o & bus_a.ls_ack_o}, 32'd0);
      if (q_a.size() == 0) chk("a_unexp_ack", 32'd1, 32'd0);
      else begin
        e_a = q_a.pop_front();
        chk("a_who",  {31'd0, bus_a.ls_ack_o}, {31'd0, e_a.is_ls});
        chk("a_addr", bus_a.mem_addr_o, e_a.addr);
        chk("a_data", bus_a.ls_ack_o ? bus_a.ls_data_o : bus_a.if_data_o, e_a.data);
      end
    end
    if (rst && (bus_b.if_ack_o || bus_b.ls_ack_o)) begin
      chk("b_ack_excl", {31'd0, bus_b.if_ack_o & bus_b.ls_ack_o}, 32'd0);
      if (q_b.size() == 0) chk("b_unexp_ack", 32'd1, 32'd0);
      else begin
        e_b = q_b.pop_front();
        chk("b_who",  {31'd0, bus_b.ls_ack_o}, {31'd0, e_b.is_ls});
        chk("b_addr", bus_b.mem_addr_o, e_b.addr);
        chk("b_data", bus_b.ls_ack_o ? bus_b.ls_data_o : bus_b.if_data_o, e_b.data);
      end
    end
  end

  initial begin
    int n_ack;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    bus_a.if_req_i = 1'b0; bus_a.if_addr_i = '0; bus_a.ls_req_i = 1'b0; bus_a.ls_we_i = 1'b0;
    bus_a.ls_addr_i = '0;  bus_a.ls_data_i = '0; bus_a.ls_sel_i = '0;
    bus_b.if_req_i = 1'b0; bus_b.if_addr_i = '0; bus_b.ls_req_i = 1'b0; bus_b.ls_we_i = 1'b0;
    bus_b.ls_addr_i = '0;  bus_b.ls_data_i = '0; bus_b.ls_sel_i = '0;

    // Reset state
    smp();
    chk("rst_ce",   {31'd0, bus_a.mem_ce_o}, 32'd0);
    chk("rst_we",   {31'd0, bus_a.mem_we_o}, 32'd0);
    chk("rst_addr", bus_a.mem_addr_o, 32'd0);
    chk("rst_data", bus_a.mem_data_o, 32'd0);
    chk("rst_sel",  {28'd0, bus_a.mem_sel_o}, 32'd0);
    chk("rst_acks", {30'd0, bus_a.if_ack_o, bus_a.ls_ack_o}, 32'd0);
    chk("rst_b_ce", {31'd0, bus_b.mem_ce_o}, 32'd0);
    tick(); rst = 1'b1;

    // Reset while BUSY aborts the fetch: no ack afterwards
    tick(); bus_a.if_req_i = 1'b1; bus_a.if_addr_i = 32'h40;
    tick(); smp();
    chk("abort_ce_busy", {31'd0, bus_a.mem_ce_o}, 32'd1);
    tick(); rst = 1'b0; bus_a.if_req_i = 1'b0;
    smp();
    chk("abort_ce",   {31'd0, bus_a.mem_ce_o}, 32'd0);
    chk("abort_addr", bus_a.mem_addr_o, 32'd0);
    chk("abort_sel",  {28'd0, bus_a.mem_sel_o}, 32'd0);
    chk("abort_ack",  {30'd0, bus_a.if_ack_o, bus_a.ls_ack_o}, 32'd0);
    tick(); tick(); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); smp();
      chk("post_rst_ce",    {31'd0, bus_a.mem_ce_o},    32'd0);
      chk("post_rst_stall", {31'd0, bus_a.stall_req_o}, 32'd0);
    end

    // WAIT_CYCLES=0 lone fetch: ack in the first BUSY cycle
    tick(); bus_b.if_req_i = 1'b1; bus_b.if_addr_i = 32'h0000_0100;
    q_b.push_back('{is_ls: 1'b0, addr: 32'h0000_0100, data: 32'hDEAD_BEEF});
    smp();
    chk("b_if_ce_pre",    {31'd0, bus_b.mem_ce_o},    32'd0);
    chk("b_if_stall_pre", {31'd0, bus_b.stall_req_o}, 32'd1);
    tick(); smp();
    chk("b_if_ce",   {31'd0, bus_b.mem_ce_o}, 32'd1);
    chk("b_if_ack",  {31'd0, bus_b.if_ack_o}, 32'd1);
    chk("b_if_data", bus_b.if_data_o, 32'hDEAD_BEEF);
    tick(); bus_b.if_req_i = 1'b0; smp();
    chk("b_if_ce_post",    {31'd0, bus_b.mem_ce_o},    32'd0);
    chk("b_if_stall_post", {31'd0, bus_b.stall_req_o}, 32'd0);

    // WAIT_CYCLES=2 store: three BUSY cycles, ack on the third
    tick(); bus_a.ls_req_i = 1'b1; bus_a.ls_we_i = 1'b1; bus_a.ls_addr_i = 32'h0200_4000;
    bus_a.ls_data_i = 32'h1234_5678; bus_a.ls_sel_i = 4'b0011;
    q_a.push_back('{is_ls: 1'b1, addr: 32'h0200_4000, data: 32'h0});
    smp();
    for (int k = 1; k <= 3; k++) begin
      tick(); smp();
      chk("st_we",   {31'd0, bus_a.mem_we_o}, 32'd1);
      chk("st_addr", bus_a.mem_addr_o, 32'h0200_4000);
      chk("st_data", bus_a.mem_data_o, 32'h1234_5678);
      chk("st_sel",  {28'd0, bus_a.mem_sel_o}, 32'h3);
      chk("st_ack",  {31'd0, bus_a.ls_ack_o}, (k == 3) ? 32'd1 : 32'd0);
    end
    tick(); bus_a.ls_req_i = 1'b0; bus_a.ls_we_i = 1'b0; smp();
    chk("st_idle_ce", {31'd0, bus_a.mem_ce_o}, 32'd0);
    chk("st_idle_we", {31'd0, bus_a.mem_we_o}, 32'd0);

    // Simultaneous IF+LS with WAIT_CYCLES=0: LS then IF back-to-back
    tick(); bus_b.if_req_i = 1'b1; bus_b.if_addr_i = 32'h300;
    bus_b.ls_req_i = 1'b1; bus_b.ls_we_i = 1'b0; bus_b.ls_addr_i = 32'h400; bus_b.ls_sel_i = 4'hF;
    q_b.push_back('{is_ls: 1'b1, addr: 32'h400, data: 32'hDEAD_BEEF});
    q_b.push_back('{is_ls: 1'b0, addr: 32'h300, data: 32'hDEAD_BEEF});
    smp();
    tick(); smp();
    chk("b2b_ls_ack", {31'd0, bus_b.ls_ack_o}, 32'd1);
    tick(); bus_b.ls_req_i = 1'b0; smp();
    chk("b2b_if_ack",  {31'd0, bus_b.if_ack_o}, 32'd1);
    chk("b2b_no_gap",  {31'd0, bus_b.mem_ce_o}, 32'd1);
    chk("b2b_if_addr", bus_b.mem_addr_o, 32'h300);
    tick(); bus_b.if_req_i = 1'b0; smp();
    chk("b2b_idle_ce", {31'd0, bus_b.mem_ce_o}, 32'd0);

    // LS streak limit (MAX_LS_STREAK=2): IF withdraws while each LS runs, so two LS
    // grants accumulate with IF requesting; the third contested pick goes to IF.
    tick(); bus_a.if_req_i = 1'b1; bus_a.if_addr_i = 32'h500;
    bus_a.ls_req_i = 1'b1; bus_a.ls_we_i = 1'b0; bus_a.ls_addr_i = 32'h600; bus_a.ls_sel_i = 4'hF;
    q_a.push_back('{is_ls: 1'b1, addr: 32'h600, data: rd_a(32'h600)});
    tick(); bus_a.if_req_i = 1'b0;
    tick(); tick(); smp();
    chk("stk_ls1_ack", {31'd0, bus_a.ls_ack_o}, 32'd1);
    tick(); bus_a.ls_addr_i = 32'h604; bus_a.if_req_i = 1'b1;
    q_a.push_back('{is_ls: 1'b1, addr: 32'h604, data: rd_a(32'h604)});
    tick(); bus_a.if_req_i = 1'b0;
    tick(); tick(); smp();
    chk("stk_ls2_ack", {31'd0, bus_a.ls_ack_o}, 32'd1);
    tick(); bus_a.ls_addr_i = 32'h608; bus_a.if_req_i = 1'b1;
    q_a.push_back('{is_ls: 1'b0, addr: 32'h500, data: rd_a(32'h500)});
    q_a.push_back('{is_ls: 1'b1, addr: 32'h608, data: rd_a(32'h608)});
    tick(); tick(); tick(); smp();
    chk("stk_if_ack", {31'd0, bus_a.if_ack_o}, 32'd1);
    tick(); bus_a.if_req_i = 1'b0;
    tick(); tick(); smp();
    chk("stk_ls3_ack", {31'd0, bus_a.ls_ack_o}, 32'd1);
    tick(); bus_a.ls_req_i = 1'b0;

    // IF drops req mid-transaction: single ack, then idle
    tick(); bus_a.if_req_i = 1'b1; bus_a.if_addr_i = 32'h700;
    q_a.push_back('{is_ls: 1'b0, addr: 32'h700, data: rd_a(32'h700)});
    tick(); bus_a.if_req_i = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (bus_a.if_ack_o) n_ack++;
      tick();
    end
    chk("drop_ack_cnt", 32'(n_ack), 32'd1);
    smp();
    chk("drop_idle_ce",    {31'd0, bus_a.mem_ce_o},    32'd0);
    chk("drop_idle_stall", {31'd0, bus_a.stall_req_o}, 32'd0);

    for (int i = 0; i < 50 && (q_a.size() + q_b.size()) != 0; i++) tick();
    chk("sb_drain", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
